// File: rtl/gpio_cfg_pkg.sv
// Shared types and defaults for the GPIO pad configuration chain:
// loader state encoding plus default chain geometry and serial divider.
package gpio_cfg_pkg;

    localparam int GPIO_CFG_WIDTH     = 13;
    localparam int GPIO_NUM_PER_CHAIN = 19;
    localparam int GPIO_SERIAL_DIV    = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SHIFT,
        ST_LOAD,
        ST_DONE
    } ldr_state_e;

    // Index width that stays legal for a single-entry range.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gpio_serial_loader_if.sv
// Bundle between the chain loader, the housekeeping register file and the pad chain.
// master = loader side, slave = register file / chain side.
interface gpio_serial_loader_if #(
    parameter int NUM_GPIO  = gpio_cfg_pkg::GPIO_NUM_PER_CHAIN,
    parameter int CFG_WIDTH = gpio_cfg_pkg::GPIO_CFG_WIDTH
);
    localparam int IDX_W = gpio_cfg_pkg::idx_width(NUM_GPIO);

    logic                 start;
    logic [IDX_W-1:0]     cfg_idx;
    logic [CFG_WIDTH-1:0] cfg_data;
    logic                 serial_clock;
    logic                 serial_data;
    logic                 serial_load;
    logic                 busy;
    logic                 done;

    modport master (
        input  start, cfg_data,
        output cfg_idx, serial_clock, serial_data, serial_load, busy, done
    );

    modport slave (
        output start, cfg_data,
        input  cfg_idx, serial_clock, serial_data, serial_load, busy, done
    );

endinterface

// File: rtl/gpio_serial_tick.sv
// Half-period divider for the serial chain clock: tick on the last cycle of
// each CLK_DIV-cycle half period, phase flips on every tick.
module gpio_serial_tick import gpio_cfg_pkg::*; #(
    parameter int CLK_DIV = GPIO_SERIAL_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick,
    output logic phase
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (clear) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (tick) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gpio_serial_loader.sv
// Walks the GPIO config words from highest index down, shifting each MSB first
// into the pad chain on a divided clock, then strobes serial_load once.
module gpio_serial_loader import gpio_cfg_pkg::*; #(
    parameter int NUM_GPIO  = GPIO_NUM_PER_CHAIN,
    parameter int CFG_WIDTH = GPIO_CFG_WIDTH,
    parameter int CLK_DIV   = GPIO_SERIAL_DIV
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rstn_i,
    gpio_serial_loader_if.master   bus
);

    localparam int IDX_W = idx_width(NUM_GPIO);
    localparam int BIT_W = idx_width(CFG_WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_GPIO - 1);

    ldr_state_e           state_q, state_d;
    logic [CFG_WIDTH-1:0] shreg;
    logic [BIT_W-1:0]     bit_cnt;
    logic [IDX_W-1:0]     idx_q;
    logic                 sclk_q, load_q, busy_q, done_q;
    logic                 tick, phase, div_clr, bit_end;

    // Divider only runs in SHIFT/LOAD, so every word starts its timing from zero.
    assign div_clr = (state_q != ST_SHIFT) && (state_q != ST_LOAD);
    assign bit_end = (state_q == ST_SHIFT) && tick && phase;

    gpio_serial_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (wb_clk_i),
        .rst_n (wb_rstn_i),
        .clear (div_clr),
        .tick  (tick),
        .phase (phase)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_LATCH;
            ST_LATCH: state_d = ST_SHIFT;
            ST_SHIFT: if (bit_end && bit_cnt == '0)
                          state_d = (idx_q != '0) ? ST_LATCH : ST_LOAD;
            ST_LOAD:  if (tick) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_q <= ST_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            idx_q   <= IDX_LAST;
            sclk_q  <= 1'b0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            // Registered copy of the divider phase; drops on the same edge data shifts.
            sclk_q  <= (state_q == ST_SHIFT) && (phase ^ tick);
            load_q  <= (state_d == ST_LOAD);
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
            if (state_q == ST_LATCH) begin
                shreg   <= bus.cfg_data;
                bit_cnt <= BIT_W'(CFG_WIDTH - 1);
            end else if (bit_end) begin
                shreg   <= shreg << 1;
                bit_cnt <= bit_cnt - 1'b1;
                if (bit_cnt == '0 && idx_q != '0)
                    idx_q <= idx_q - 1'b1;
            end
            if (state_q == ST_DONE)
                idx_q <= IDX_LAST;
        end
    end

    assign bus.cfg_idx      = idx_q;
    assign bus.serial_clock = sclk_q;
    assign bus.serial_data  = shreg[CFG_WIDTH-1];
    assign bus.serial_load  = load_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Directed bench: small chain (2x4, div 1) for ordering/boundary cases and the
// default 19x13 div-4 chain for full-length timing and a chain scoreboard.
module tb_gpio_serial_loader;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gpio_serial_loader_if #(.NUM_GPIO(2),  .CFG_WIDTH(4))  ifa ();
    gpio_serial_loader_if #(.NUM_GPIO(19), .CFG_WIDTH(13)) ifb ();

    gpio_serial_loader #(.NUM_GPIO(2), .CFG_WIDTH(4), .CLK_DIV(1)) dut_a (
        .wb_clk_i (clk), .wb_rstn_i (rst_n), .bus (ifa)
    );
    gpio_serial_loader #(.NUM_GPIO(19), .CFG_WIDTH(13), .CLK_DIV(4)) dut_b (
        .wb_clk_i (clk), .wb_rstn_i (rst_n), .bus (ifb)
    );

    logic [3:0]  word_a [2];
    logic [12:0] word_b [19];
    logic        glitch_a;
    logic [3:0]  junk_a;

    assign ifa.cfg_data = glitch_a ? junk_a : word_a[ifa.cfg_idx];
    assign ifb.cfg_data = word_b[ifb.cfg_idx];

    int checks = 0;
    int failures = 0;

    // Chain models: shift in serial_data on every serial_clock rising edge.
    logic [7:0]   chain_a = '0;
    logic [246:0] chain_b = '0;
    logic sclk_prev_a = 1'b0, sdat_prev_a = 1'b0, sclk_prev_b = 1'b0, sdat_prev_b = 1'b0;
    int rises_a = 0, load_a = 0, done_a = 0, hichg_a = 0, ovl_a = 0;
    int rises_b = 0, load_b = 0, done_b = 0, hichg_b = 0, ovl_b = 0;

    always @(negedge clk) begin
        if (ifa.serial_clock && !sclk_prev_a) begin
            rises_a++;
            chain_a = {chain_a[6:0], ifa.serial_data};
        end
        if (ifa.serial_clock && sclk_prev_a && ifa.serial_data !== sdat_prev_a) hichg_a++;
        if (ifa.serial_load) load_a++;
        if (ifa.serial_load && ifa.serial_clock) ovl_a++;
        if (ifa.done) done_a++;
        sclk_prev_a = ifa.serial_clock;
        sdat_prev_a = ifa.serial_data;
    end

    always @(negedge clk) begin
        if (ifb.serial_clock && !sclk_prev_b) begin
            rises_b++;
            chain_b = {chain_b[245:0], ifb.serial_data};
        end
        if (ifb.serial_clock && sclk_prev_b && ifb.serial_data !== sdat_prev_b) hichg_b++;
        if (ifb.serial_load) load_b++;
        if (ifb.serial_load && ifb.serial_clock) ovl_b++;
        if (ifb.done) done_b++;
        sclk_prev_b = ifb.serial_clock;
        sdat_prev_b = ifb.serial_data;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench on the negedge just after the accepting edge.
    task automatic go_a();
        @(negedge clk) ifa.start = 1'b1;
        @(negedge clk) ifa.start = 1'b0;
    endtask

    task automatic go_b();
        @(negedge clk) ifb.start = 1'b1;
        @(negedge clk) ifb.start = 1'b0;
    endtask

    // n = cycles from acceptance to done, fr = cycle of first serial_clock high.
    task automatic wait_a(output int n, output int fr);
        n = 0; fr = -1;
        while (!ifa.done && n < 200) begin
            @(negedge clk); n++;
            if (fr < 0 && ifa.serial_clock) fr = n;
        end
    endtask

    task automatic wait_b(output int n, output int fr);
        n = 0; fr = -1;
        while (!ifb.done && n < 3000) begin
            @(negedge clk); n++;
            if (fr < 0 && ifb.serial_clock) fr = n;
        end
    endtask

    initial begin
        int n, fr, r0, l0, d0;
        rst_n = 1'b1;
        ifa.start = 1'b0; ifb.start = 1'b0;
        glitch_a = 1'b0; junk_a = '0;
        word_a[1] = 4'hA; word_a[0] = 4'h3;
        for (int i = 0; i < 19; i++) word_b[i] = 13'h1803 + 13'(i);
        #1 rst_n = 1'b0;
        #20;
        chk("reset_a", 64'({ifa.cfg_idx, ifa.serial_clock, ifa.serial_data,
                             ifa.serial_load, ifa.busy, ifa.done}), 64'h20);
        chk("reset_b", 64'({ifb.cfg_idx, ifb.serial_clock, ifb.serial_data,
                             ifb.serial_load, ifb.busy, ifb.done}), 64'h240);
        @(negedge clk) rst_n = 1'b1;

        // Basic load, then a start in the DONE cycle (ignored) and a back-to-back start.
        r0 = rises_a; l0 = load_a; d0 = done_a;
        go_a();
        chk("basic_busy", 64'(ifa.busy), 64'd1);
        wait_a(n, fr);
        chk("basic_first_rise", 64'(fr), 64'd2);
        chk("basic_done_time", 64'(n), 64'd19);
        chk("basic_rises", 64'(rises_a - r0), 64'd8);
        chk("basic_bits", 64'(chain_a), 64'hA3);
        chk("basic_load_cycles", 64'(load_a - l0), 64'd1);
        ifa.start = 1'b1;
        @(negedge clk) ifa.start = 1'b0;
        chk("done_cycle_start_ignored", 64'(ifa.busy), 64'd0);
        ifa.start = 1'b1;
        @(negedge clk) ifa.start = 1'b0;
        chk("b2b_busy", 64'(ifa.busy), 64'd1);
        chk("b2b_idx", 64'(ifa.cfg_idx), 64'd1);
        wait_a(n, fr);
        chk("b2b_done_time", 64'(n), 64'd19);
        chk("b2b_bits", 64'(chain_a), 64'hA3);
        repeat (3) @(negedge clk);
        chk("b2b_done_count", 64'(done_a - d0), 64'd2);

        // Start while busy: extra pulses at cycle 5 and during LOAD are dropped.
        r0 = rises_a; l0 = load_a; d0 = done_a;
        go_a();
        n = 0;
        while (!ifa.done && n < 200) begin
            @(negedge clk); n++;
            ifa.start = (n == 4) || ifa.serial_load;
        end
        ifa.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_start_done_count", 64'(done_a - d0), 64'd1);
        chk("busy_start_rises", 64'(rises_a - r0), 64'd8);
        chk("busy_start_load", 64'(load_a - l0), 64'd1);
        chk("busy_start_idle", 64'(ifa.busy), 64'd0);

        // cfg_data glitching: only the LATCH cycles (0 and 9) present real data.
        word_a[1] = 4'hC; word_a[0] = 4'h5;
        glitch_a = 1'b1;
        junk_a = 4'h0;
        go_a();
        junk_a = word_a[ifa.cfg_idx];
        n = 0;
        while (!ifa.done && n < 200) begin
            @(negedge clk); n++;
            junk_a = (n == 9) ? word_a[ifa.cfg_idx]
                              : (word_a[ifa.cfg_idx] ^ 4'($urandom_range(1, 15)));
        end
        glitch_a = 1'b0;
        chk("glitch_bits", 64'(chain_a), 64'hC5);
        chk("glitch_done_time", 64'(n), 64'd19);

        // Reset during the low phase of the 3rd bit; outputs clear without a clock edge.
        word_a[1] = 4'hA; word_a[0] = 4'h3;
        l0 = load_a;
        go_a();
        n = 0;
        while (n < 5) begin @(negedge clk); n++; end
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 64'({ifa.cfg_idx, ifa.serial_clock, ifa.serial_data,
                                         ifa.serial_load, ifa.busy, ifa.done}), 64'h20);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_no_load", 64'(load_a - l0), 64'd0);
        go_a();
        wait_a(n, fr);
        chk("post_reset_done_time", 64'(n), 64'd19);
        chk("post_reset_bits", 64'(chain_a), 64'hA3);

        // Default geometry: 19 words of 13 bits, divider 4.
        r0 = rises_b; l0 = load_b; d0 = done_b;
        go_b();
        wait_b(n, fr);
        chk("dflt_first_rise", 64'(fr), 64'd5);
        chk("dflt_done_time", 64'(n), 64'd1999);
        chk("dflt_rises", 64'(rises_b - r0), 64'd247);
        chk("dflt_load_cycles", 64'(load_b - l0), 64'd4);
        for (int i = 0; i < 19; i++)
            chk($sformatf("dflt_word%0d", i), 64'(chain_b[i*13 +: 13]), 64'(word_b[i]));
        repeat (3) @(negedge clk);
        chk("dflt_done_count", 64'(done_b - d0), 64'd1);
        chk("dflt_idle", 64'({ifb.busy, ifb.cfg_idx}), 64'd18);

        chk("data_stable_while_high", 64'(hichg_a + hichg_b), 64'd0);
        chk("load_never_with_sclk", 64'(ovl_a + ovl_b), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
